// File: rtl/logic_op_pipe_pkg.sv
// Shared definitions for the logical-operation pipe: op-code encodings
// used by the execute stage and by the pipe itself.
package logic_op_pipe_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

endpackage

// File: rtl/logic_op_pipe_if.sv
// Issue-side request and writeback-side result channels of the logic-op pipe.
// The master is the issue/writeback environment; the slave is the unit.
interface logic_op_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_neg_b;
  logic             in_neg_res;
  logic [0:WIDTH-1] in_a;
  logic [0:WIDTH-1] in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] out_y;
  logic             out_zero;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_neg_b, in_neg_res, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_neg_b, in_neg_res, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_err, out_tag
  );
endinterface

// File: rtl/logic_op_fifo2.sv
// Two-entry result buffer with 1-bit wrapping pointers. A push together with
// a pop is accepted even when full; the whole buffer clears on reset.
module logic_op_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [2];
  logic          head;
  logic          tail;
  logic [1:0]    count;
  logic          wr;
  logic          rd;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[tail] <= din;
        tail      <= ~tail;
      end
      if (rd) head <= ~head;
      case ({wr, rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Pipelined AND/OR/XOR unit: input register stage, combinational compute,
// then a 2-entry result buffer toward writeback.
module logic_op_pipe
  import logic_op_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  logic_op_pipe_if.slave bus
);
  localparam int ENT_W = WIDTH + 2 + TAG_W;

  function automatic logic [0:WIDTH-1] logic_calc(
    input logic [1:0]       op,
    input logic             neg_b,
    input logic             neg_res,
    input logic [0:WIDTH-1] a,
    input logic [0:WIDTH-1] b
  );
    logic [0:WIDTH-1] bb;
    logic [0:WIDTH-1] r;
    bb = neg_b ? ~b : b;
    case (op)
      OP_AND:  r = a & bb;
      OP_OR:   r = a | bb;
      OP_XOR:  r = a ^ bb;
      default: r = '0;
    endcase
    // An illegal op yields zero regardless of the complement request.
    if (op == OP_ILL) logic_calc = '0;
    else              logic_calc = neg_res ? ~r : r;
  endfunction

  logic             vld_p1;
  logic [1:0]       op_p1;
  logic             neg_b_p1;
  logic             neg_res_p1;
  logic [0:WIDTH-1] a_p1;
  logic [0:WIDTH-1] b_p1;
  logic [TAG_W-1:0] tag_p1;

  logic             accept;
  logic             drain;
  logic             pop;
  logic             out_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic [0:WIDTH-1] y_p2;
  logic             zero_p2;
  logic             err_p2;
  logic [ENT_W-1:0] din_p2;
  logic [ENT_W-1:0] dout;

  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && bus.out_ready;
  assign drain        = vld_p1 && (!fifo_full || pop);
  assign bus.in_ready = !vld_p1 || drain;
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage S1: input register
  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (accept) vld_p1 <= 1'b1;
    else if (drain)  vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1      <= bus.in_op;
      neg_b_p1   <= bus.in_neg_b;
      neg_res_p1 <= bus.in_neg_res;
      a_p1       <= bus.in_a;
      b_p1       <= bus.in_b;
      tag_p1     <= bus.in_tag;
    end
  end

  // Stage S2: compute and write into the result buffer
  assign y_p2    = logic_calc(op_p1, neg_b_p1, neg_res_p1, a_p1, b_p1);
  assign zero_p2 = (y_p2 == '0);
  assign err_p2  = (op_p1 == OP_ILL);
  assign din_p2  = {y_p2, zero_p2, err_p2, tag_p1};

  logic_op_fifo2 #(.DW(ENT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (drain),
    .pop   (pop),
    .din   (din_p2),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = out_valid;
  assign {bus.out_y, bus.out_zero, bus.out_err, bus.out_tag} = dout;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: accepted requests push a model result,
// every writeback pop is compared against the queue head.
module tb_logic_op_pipe;
  localparam int W = 32;
  localparam int T = 5;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_done = 1'b0;
  exp_t sb[$];

  logic_op_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

  logic_op_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic nb, input logic nr,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    exp_t e;
    logic [31:0] bo;
    logic [31:0] r;
    bo = b;
    if (nb) bo = ~b;
    r = 32'h0;
    if (op == 2'b00) r = a & bo;
    if (op == 2'b01) r = a | bo;
    if (op == 2'b10) r = a ^ bo;
    if (nr) r = ~r;
    e.err  = (op == 2'b11);
    e.y    = e.err ? 32'h0 : r;
    e.zero = (e.y == 32'h0);
    e.tag  = tag;
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("stale_out", 64'(bus.out_tag), 64'h3f);
        end else begin
          e = sb.pop_front();
          check_eq("out_y", 64'(bus.out_y), 64'(e.y));
          check_eq("out_zero", 64'(bus.out_zero), 64'(e.zero));
          check_eq("out_err", 64'(bus.out_err), 64'(e.err));
          check_eq("out_tag", 64'(bus.out_tag), 64'(e.tag));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_op, bus.in_neg_b, bus.in_neg_res, bus.in_a, bus.in_b, bus.in_tag));
    end
  end

  task automatic drive(input logic [1:0] op, input logic nb, input logic nr,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_neg_b   = nb;
    bus.in_neg_res = nr;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_tag     = tag;
  endtask

  task automatic send(input logic [1:0] op, input logic nb, input logic nr,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    drive(op, nb, nr, a, b, tag);
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_eq("accept_timeout", 64'(bus.in_ready), 64'h1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1 check_eq("drained", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    int c0;
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check_eq("rst_out_y", 64'(bus.out_y), 64'h0);
    check_eq("rst_out_zero", 64'(bus.out_zero), 64'h0);
    check_eq("rst_out_err", 64'(bus.out_err), 64'h0);
    check_eq("rst_out_tag", 64'(bus.out_tag), 64'h0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'h1);
    @(posedge clk);
    #1;

    // First request and its latency
    send(2'b01, 1'b0, 1'b0, 32'h00F010FF, 32'h0, 5'd3);
    @(negedge clk);
    check_eq("lat_early", 64'(bus.out_valid), 64'h0);
    @(negedge clk);
    check_eq("lat_k1", 64'(bus.out_valid), 64'h1);
    @(posedge clk);
    #1;

    // Back-to-back vectors at full throughput
    c0 = cyc;
    send(2'b01, 1'b0, 1'b0, 32'h00F010FF, 32'h00FFF000, 5'd4);
    send(2'b00, 1'b1, 1'b0, 32'h00F010FF, 32'h00FFF000, 5'd5);
    send(2'b10, 1'b0, 1'b1, 32'h00F010FF, 32'h00FFF000, 5'd6);
    send(2'b00, 1'b0, 1'b0, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd7);
    send(2'b00, 1'b0, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd8);
    send(2'b10, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd9);
    check_eq("throughput", 64'(cyc - c0), 64'd6);
    drain_all();

    // Back-pressure: three absorbed, fourth waits for the first pop
    bus.out_ready = 1'b0;
    send(2'b01, 1'b0, 1'b0, 32'h11110000, 32'h00002222, 5'd10);
    send(2'b00, 1'b0, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 5'd11);
    send(2'b10, 1'b0, 1'b0, 32'h12345678, 32'h87654321, 5'd12);
    drive(2'b01, 1'b1, 1'b0, 32'h0, 32'h0000FFFF, 5'd13);
    @(negedge clk);
    check_eq("bp_in_ready0", 64'(bus.in_ready), 64'h0);
    @(negedge clk);
    check_eq("bp_in_ready1", 64'(bus.in_ready), 64'h0);
    check_eq("bp_head_tag", 64'(bus.out_tag), 64'd10);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_accept_on_pop", 64'(bus.in_ready), 64'h1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_stream_valid", 64'(bus.out_valid), 64'h1);
    end
    @(negedge clk);
    check_eq("bp_empty", 64'(bus.out_valid), 64'h0);
    @(posedge clk);
    #1;

    // Illegal op, then a legal one
    send(2'b11, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd17);
    send(2'b01, 1'b0, 1'b0, 32'h00000001, 32'h0, 5'd18);
    drain_all();

    // Randomised traffic with random writeback stalls
    fork
      begin
        for (int i = 0; i < 24; i++)
          send(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               $urandom, $urandom, 5'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom);
        end
      end
    join
    drain_all();

    // Reset with three requests in flight
    bus.out_ready = 1'b0;
    send(2'b01, 1'b0, 1'b0, 32'h1, 32'h2, 5'd20);
    send(2'b01, 1'b0, 1'b0, 32'h3, 32'h4, 5'd21);
    send(2'b01, 1'b0, 1'b0, 32'h5, 32'h6, 5'd22);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'h1);
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("midrst_no_stale", 64'(bus.out_valid), 64'h0);
    check_eq("midrst_sb_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
